pc_redirect_ctrl: RTL and testbench

// Next-PC sequencer for the VLIW fetch stage; drives the PC register's npc/npc_enn/n_stall inputs.

---
 rtl/pc_ctrl_pkg.sv | 16 +
 rtl/sat_counter.sv | 19 +
 rtl/pc_redirect_ctrl.sv | 147 ++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the fetch-stage next-PC sequencer.
package pc_ctrl_pkg;

  localparam int PC_W = 25;

  typedef enum logic {RUN, HALT} pc_state_t;

  // Encoding order is the redirect priority: a larger value is an older instruction.
  typedef enum logic [1:0] {SRC_NONE, SRC_ID, SRC_EX} redir_src_t;

  // A candidate redirect wins over a held one when it is at least as old.
  function automatic logic outranks(redir_src_t cand, logic held_valid, redir_src_t held);
    return (cand != SRC_NONE) && (!held_valid || (cand >= held));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for fetch performance statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer: age-ordered redirect arbitration, stall merging,
// pending-redirect hold and HALT/RESUME control for the fetch stage.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W  = pc_ctrl_pkg::PC_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_br_valid,
  input  logic [PC_W-1:0]  ex_br_target,
  input  logic             id_jmp_valid,
  input  logic [PC_W-1:0]  id_jmp_target,
  input  logic             hz_stall,
  input  logic             mem_stall,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic [PC_W-1:0]  resume_target,
  output logic [PC_W-1:0]  npc,
  output logic             npc_enn,
  output logic             n_stall,
  output logic             flush_if,
  output logic             flush_id,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  pc_state_t       state, state_nx;
  logic            pend_v_q, pend_v_nx;
  logic [PC_W-1:0] pend_t_q, pend_t_nx;
  redir_src_t      pend_s_q, pend_s_nx;

  redir_src_t      live_src, sel_src;
  logic [PC_W-1:0] live_tgt, sel_tgt;
  logic            stall_inc;

  always_comb begin
    live_src = SRC_NONE;
    live_tgt = '0;
    if (ex_br_valid) begin
      live_src = SRC_EX;
      live_tgt = ex_br_target;
    end else if (id_jmp_valid) begin
      live_src = SRC_ID;
      live_tgt = id_jmp_target;
    end
  end

  always_comb begin
    npc       = '0;
    npc_enn   = 1'b0;
    n_stall   = 1'b1;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    state_nx  = state;
    pend_v_nx = pend_v_q;
    pend_t_nx = pend_t_q;
    pend_s_nx = pend_s_q;
    sel_src   = SRC_NONE;
    sel_tgt   = '0;

    if (rst) begin
      state_nx  = RUN;
      pend_v_nx = 1'b0;
      pend_s_nx = SRC_NONE;
    end else begin
      unique case (state)
        HALT: begin
          n_stall = 1'b0;
          if (resume_req) begin
            npc      = resume_target;
            npc_enn  = 1'b1;
            n_stall  = 1'b1;
            flush_if = 1'b1;
            flush_id = 1'b1;
            state_nx = RUN;
          end
        end
        RUN: begin
          // EX redirect squashes the instruction causing the hazard, so it lifts hz_stall.
          n_stall = !(mem_stall | (hz_stall & !ex_br_valid));
          if (n_stall) begin
            if (outranks(live_src, pend_v_q, pend_s_q)) begin
              sel_src = live_src;
              sel_tgt = live_tgt;
            end else if (pend_v_q) begin
              sel_src = pend_s_q;
              sel_tgt = pend_t_q;
            end
            pend_v_nx = 1'b0;
            pend_s_nx = SRC_NONE;
            if (sel_src != SRC_NONE) begin
              npc      = sel_tgt;
              npc_enn  = 1'b1;
              flush_if = 1'b1;
              flush_id = (sel_src == SRC_EX);
            end
          end else if (outranks(live_src, pend_v_q, pend_s_q)) begin
            pend_v_nx = 1'b1;
            pend_t_nx = live_tgt;
            pend_s_nx = live_src;
          end
          if (halt_req) begin
            state_nx  = HALT;
            pend_v_nx = 1'b0;
            pend_s_nx = SRC_NONE;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pend_v_q <= 1'b0;
      pend_t_q <= '0;
      pend_s_q <= SRC_NONE;
    end else begin
      state    <= state_nx;
      pend_v_q <= pend_v_nx;
      pend_t_q <= pend_t_nx;
      pend_s_q <= pend_s_nx;
    end
  end

  assign halted    = !rst && (state == HALT);
  assign stall_inc = !rst && (state == RUN) && !n_stall;

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk (clk),
    .rst (rst),
    .inc (npc_enn),
    .q   (redirect_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .q   (stall_cnt)
  );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed vector table plus randomized traffic
// checked against a priority-based reference model.
module tb_pc_redirect_ctrl;

  localparam int PW = 25;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, ex_br_valid, id_jmp_valid, hz_stall, mem_stall, halt_req, resume_req;
  logic [PW-1:0] ex_br_target, id_jmp_target, resume_target, npc;
  logic          npc_enn, n_stall, flush_if, flush_id, halted;
  logic [CW-1:0] redirect_cnt, stall_cnt;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.PC_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ex_br_valid(ex_br_valid), .ex_br_target(ex_br_target),
    .id_jmp_valid(id_jmp_valid), .id_jmp_target(id_jmp_target),
    .hz_stall(hz_stall), .mem_stall(mem_stall),
    .halt_req(halt_req), .resume_req(resume_req), .resume_target(resume_target),
    .npc(npc), .npc_enn(npc_enn), .n_stall(n_stall),
    .flush_if(flush_if), .flush_id(flush_id), .halted(halted),
    .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic rst, exv; logic [PW-1:0] ext;
    logic idv; logic [PW-1:0] idt;
    logic hz, mem, halt, res; logic [PW-1:0] rest;
  } stim_t;

  typedef struct {
    stim_t s;
    logic enn, nst, fi, fd, hl; logic [PW-1:0] npc;
    int rc, sc;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: priority 2 = EX (older), 1 = ID, 0 = nothing held.
  bit            m_halt, m_pv;
  logic [PW-1:0] m_pt;
  int            m_pp, m_rc, m_sc;

  task automatic model_reset();
    m_halt = 0; m_pv = 0; m_pt = '0; m_pp = 0; m_rc = 0; m_sc = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic r, exv, input int ext, input logic idv, input int idt,
                     input logic hz, mem, halt, res, input int rest,
                     input logic enn, nst, fi, fd, hl, input int enpc, input int rc, sc);
    vec_t v;
    v.s.rst = r; v.s.exv = exv; v.s.ext = PW'(ext); v.s.idv = idv; v.s.idt = PW'(idt);
    v.s.hz = hz; v.s.mem = mem; v.s.halt = halt; v.s.res = res; v.s.rest = PW'(rest);
    v.enn = enn; v.nst = nst; v.fi = fi; v.fd = fd; v.hl = hl; v.npc = PW'(enpc);
    v.rc = rc; v.sc = sc;
    tbl.push_back(v);
  endtask

  // Drive one cycle, compare at the falling edge, advance the model at the rising edge.
  task automatic apply(input stim_t s, input bit use_tbl, input vec_t v);
    logic e_enn, e_nst, e_fi, e_fd, e_hl;
    logic [PW-1:0] e_npc;
    int lp;
    logic [PW-1:0] lt;
    rst = s.rst; ex_br_valid = s.exv; ex_br_target = s.ext;
    id_jmp_valid = s.idv; id_jmp_target = s.idt; hz_stall = s.hz; mem_stall = s.mem;
    halt_req = s.halt; resume_req = s.res; resume_target = s.rest;

    lp = s.exv ? 2 : (s.idv ? 1 : 0);
    lt = s.exv ? s.ext : s.idt;
    e_enn = 0; e_nst = 1; e_fi = 0; e_fd = 0; e_hl = 0; e_npc = '0;
    if (!s.rst) begin
      if (m_halt) begin
        e_hl = 1;
        e_nst = s.res;
        if (s.res) begin e_enn = 1; e_fi = 1; e_fd = 1; e_npc = s.rest; end
      end else begin
        e_nst = !(s.mem || (s.hz && !s.exv));
        if (e_nst) begin
          if (lp > 0 && (!m_pv || lp >= m_pp)) begin
            e_enn = 1; e_fi = 1; e_fd = (lp == 2); e_npc = lt;
          end else if (m_pv) begin
            e_enn = 1; e_fi = 1; e_fd = (m_pp == 2); e_npc = m_pt;
          end
        end
      end
    end

    @(negedge clk);
    chk("npc_enn", 64'(npc_enn), 64'(e_enn));
    chk("n_stall", 64'(n_stall), 64'(e_nst));
    chk("flush_if", 64'(flush_if), 64'(e_fi));
    chk("flush_id", 64'(flush_id), 64'(e_fd));
    chk("halted", 64'(halted), 64'(e_hl));
    if (e_enn || s.rst) chk("npc", 64'(npc), 64'(e_npc));
    chk("redirect_cnt", 64'(redirect_cnt), 64'(m_rc));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_sc));
    if (use_tbl) begin
      chk("tbl_npc_enn", 64'(npc_enn), 64'(v.enn));
      chk("tbl_n_stall", 64'(n_stall), 64'(v.nst));
      chk("tbl_flush_if", 64'(flush_if), 64'(v.fi));
      chk("tbl_flush_id", 64'(flush_id), 64'(v.fd));
      chk("tbl_halted", 64'(halted), 64'(v.hl));
      if (v.enn) chk("tbl_npc", 64'(npc), 64'(v.npc));
      chk("tbl_redirect_cnt", 64'(redirect_cnt), 64'(v.rc));
      chk("tbl_stall_cnt", 64'(stall_cnt), 64'(v.sc));
    end

    @(posedge clk);
    if (s.rst) begin
      model_reset();
    end else begin
      if (e_enn && m_rc < 65535) m_rc++;
      if (!m_halt && !e_nst && m_sc < 65535) m_sc++;
      if (m_halt) begin
        if (s.res) m_halt = 0;
      end else if (s.halt) begin
        m_halt = 1; m_pv = 0; m_pp = 0;
      end else if (e_nst) begin
        m_pv = 0; m_pp = 0;
      end else if (lp > 0 && (!m_pv || lp >= m_pp)) begin
        m_pv = 1; m_pt = lt; m_pp = lp;
      end
    end
    #1;
  endtask

  initial begin
    stim_t s;
    vec_t  dummy;
    //   rst ex  ext     id idt    hz mem hlt res rest     enn nst fi fd hl npc     rc sc
    add(1, 1, 'h1,    0, 0,     0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0,       0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0,    0, 0,     0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0,       0, 0);
    add(0, 1, 'h40,   1, 'h80,  0, 0, 0, 0, 0,        1, 1, 1, 1, 0, 'h40,    0, 0);
    add(0, 0, 0,      0, 0,     0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0,       1, 0);
    add(0, 0, 0,      1, 'h10,  0, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0,       1, 0);
    add(0, 1, 'h20,   0, 0,     0, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0,       1, 1);
    add(0, 0, 0,      0, 0,     0, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0,       1, 2);
    add(0, 0, 0,      0, 0,     0, 0, 0, 0, 0,        1, 1, 1, 1, 0, 'h20,    1, 3);
    add(0, 1, 'h55,   0, 0,     1, 0, 0, 0, 0,        1, 1, 1, 1, 0, 'h55,    2, 3);
    add(0, 0, 0,      0, 0,     1, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,       3, 3);
    add(0, 0, 0,      0, 0,     0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0,       3, 4);
    add(0, 0, 0,      0, 0,     0, 0, 1, 0, 0,        0, 1, 0, 0, 0, 0,       3, 4);
    for (int i = 0; i < 5; i++)
      add(0, (i == 1), 'h99, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 0,       3, 4);
    add(0, 0, 0,      0, 0,     0, 0, 0, 1, 'h3FC0,   1, 1, 1, 1, 1, 'h3FC0,  3, 4);
    add(0, 0, 0,      0, 0,     0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0,       4, 4);
    add(0, 0, 0,      1, 'h123, 0, 0, 0, 0, 0,        1, 1, 1, 0, 0, 'h123,   4, 4);
    add(0, 1, 'h200,  0, 0,     0, 0, 1, 0, 0,        1, 1, 1, 1, 0, 'h200,   5, 4);
    add(0, 0, 0,      0, 0,     0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 0,       6, 4);
    add(0, 0, 0,      0, 0,     0, 1, 0, 1, 'h7,      1, 1, 1, 1, 1, 'h7,     6, 4);
    add(0, 0, 0,      0, 0,     0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0,       7, 4);
    add(0, 1, 'h300,  0, 0,     0, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0,       7, 4);
    add(0, 0, 0,      0, 0,     0, 1, 1, 0, 0,        0, 0, 0, 0, 0, 0,       7, 5);
    add(0, 1, 'h301,  0, 0,     0, 1, 0, 0, 0,        0, 0, 0, 0, 1, 0,       7, 6);
    add(1, 0, 0,      0, 0,     0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0,       7, 6);
    add(0, 0, 0,      0, 0,     0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0,       0, 0);
    add(0, 1, 'h310,  0, 0,     0, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0,       0, 0);
    add(1, 0, 0,      0, 0,     0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0,       0, 1);
    add(0, 0, 0,      0, 0,     0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0,       0, 0);
    add(0, 1, 'h50,   0, 0,     0, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0,       0, 0);
    add(0, 0, 0,      1, 'h60,  0, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0,       0, 1);
    add(0, 0, 0,      1, 'h70,  0, 0, 0, 0, 0,        1, 1, 1, 1, 0, 'h50,    0, 2);
    add(0, 0, 0,      0, 0,     0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0,       1, 2);
    add(0, 0, 0,      1, 'h11,  0, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0,       1, 2);
    add(0, 1, 'h22,   0, 0,     1, 0, 0, 0, 0,        1, 1, 1, 1, 0, 'h22,    1, 3);
    add(0, 0, 0,      0, 0,     0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0,       2, 3);

    rst = 1; ex_br_valid = 0; ex_br_target = '0; id_jmp_valid = 0; id_jmp_target = '0;
    hz_stall = 0; mem_stall = 0; halt_req = 0; resume_req = 0; resume_target = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    foreach (tbl[i]) apply(tbl[i].s, 1'b1, tbl[i]);

    dummy = tbl[0];
    for (int n = 0; n < 1500; n++) begin
      s.rst  = ($urandom_range(63) == 0);
      s.exv  = ($urandom_range(4) == 0);
      s.ext  = PW'($urandom);
      s.idv  = ($urandom_range(3) == 0);
      s.idt  = PW'($urandom);
      s.hz   = ($urandom_range(4) == 0);
      s.mem  = ($urandom_range(3) == 0);
      s.halt = ($urandom_range(19) == 0);
      s.res  = ($urandom_range(3) == 0);
      s.rest = PW'($urandom);
      apply(s, 1'b0, dummy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
